// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encodings and sizing helper for the digit-serial divider
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Keeps the digit index at least one bit wide when a single digit covers the dividend
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_digit_step.sv
// rtl/div_digit_step.sv - one radix-2^DGT long-division step: {residue, digit} / divisor
module div_digit_step #(
  parameter int VW  = 8,
  parameter int DGT = 8
) (
  input  logic [VW-1:0]  i_residue,
  input  logic [DGT-1:0] i_digit,
  input  logic [VW-1:0]  i_divisor,
  output logic [DGT-1:0] o_quo,
  output logic [VW-1:0]  o_rem
);

  logic [VW+DGT-1:0] w_cur;
  logic [VW+DGT-1:0] w_dvs;

  assign w_cur = {i_residue, i_digit};
  assign w_dvs = {{DGT{1'b0}}, i_divisor};

  // residue < divisor keeps the digit quotient inside DGT bits; zero divisor never reaches RUN
  always_comb begin
    o_quo = '0;
    o_rem = '0;
    if (i_divisor != '0) begin
      o_quo = DGT'(w_cur / w_dvs);
      o_rem = VW'(w_cur % w_dvs);
    end
  end

endmodule

// File: rtl/digit_serial_divider.sv
// rtl/digit_serial_divider.sv - DW-by-VW unsigned divider retiring DGT quotient bits per cycle
module digit_serial_divider
  import div_pkg::*;
#(
  parameter int DW  = 400,
  parameter int VW  = 8,
  parameter int DGT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  localparam int N  = DW / DGT;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [VW-1:0] r_residue;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [DW-1:0] r_qwork;
  logic [DW-1:0] r_quotient;
  logic [VW-1:0] r_remainder;
  logic          r_dbz;
  logic          r_done;

  logic [DGT-1:0] w_digit;
  logic [DGT-1:0] w_qdigit;
  logic [VW-1:0]  w_rem;
  logic [DW-1:0]  w_qnext;

  // Latched dividend shifts left each step so the next digit is always at the top
  assign w_digit = r_dvd[DW-1 -: DGT];
  assign w_qnext = (r_qwork << DGT) | DW'(w_qdigit);

  div_digit_step #(.VW(VW), .DGT(DGT)) u_step (
    .i_residue (r_residue),
    .i_digit   (w_digit),
    .i_divisor (r_dvs),
    .o_quo     (w_qdigit),
    .o_rem     (w_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_residue   <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_qwork     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          if (start) begin
            r_dvd     <= dividend;
            r_dvs     <= divisor;
            r_residue <= '0;
            r_idx     <= '0;
            r_qwork   <= '0;
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_residue <= w_rem;
            r_qwork   <= w_qnext;
            r_dvd     <= r_dvd << DGT;
            r_idx     <= r_idx + IW'(1);
            if (r_idx == LAST) begin
              r_quotient  <= w_qnext;
              r_remainder <= w_rem;
              r_dbz       <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_digit_serial_divider.sv
// tb/tb_digit_serial_divider.sv - scoreboard bench for digit_serial_divider
module tb_digit_serial_divider;

  localparam int DW  = 400;
  localparam int VW  = 8;
  localparam int DGT = 8;
  localparam int N   = DW / DGT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy, done, dbz;

  logic        s_start, s_abort;
  logic [63:0] s_dividend, s_quotient;
  logic [15:0] s_divisor, s_remainder;
  logic        s_busy, s_done, s_dbz;

  digit_serial_divider dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .dbz(dbz)
  );

  digit_serial_divider #(.DW(64), .VW(16), .DGT(4)) dut64 (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .dividend(s_dividend), .divisor(s_divisor),
    .quotient(s_quotient), .remainder(s_remainder),
    .busy(s_busy), .done(s_done), .dbz(s_dbz)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = '0; e.z = 1'b1;
    end else begin
      e.q = a / DW'(b);
      e.r = VW'(a % DW'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      check("sb_pending", DW'(sb.size() > 0), DW'(1));
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sb_quotient", quotient, mon_e.q);
        check("sb_remainder", DW'(remainder), DW'(mon_e.r));
        check("sb_dbz", DW'(dbz), DW'(mon_e.z));
      end
    end
  end

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input int lat, input int busy_exp, input bit disturb);
    int c, nb;
    bit seen;
    sb.push_back(model(a, b));
    start = 1'b1; dividend = a; divisor = b;
    c = 0; nb = 0; seen = 1'b0;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) start = 1'b0;
      if (busy) nb++;
      if (done) seen = 1'b1;
      if (disturb && c == 10) begin
        start = 1'b1; dividend = ~a; divisor = b + 8'd1;
      end
      if (disturb && c == 11) start = 1'b0;
    end
    check("done_latency", DW'(c - 1), DW'(lat));
    check("busy_cycles", DW'(nb), DW'(busy_exp));
    @(negedge clk);
    check("done_one_cycle", DW'(done), DW'(0));
  endtask

  task automatic check_outputs(input string tag, input logic [DW-1:0] q, input logic [VW-1:0] r,
                               input logic z, input logic b);
    check({tag, "_q"}, quotient, q);
    check({tag, "_r"}, DW'(remainder), DW'(r));
    check({tag, "_dbz"}, DW'(dbz), DW'(z));
    check({tag, "_busy"}, DW'(busy), DW'(b));
    check({tag, "_done"}, DW'(done), DW'(0));
  endtask

  logic [DW-1:0] a, ones;
  int c;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; dividend = '0; divisor = '0;
    s_start = 1'b0; s_abort = 1'b0; s_dividend = '0; s_divisor = '0;
    ones = '1;
    repeat (2) @(negedge clk);
    check_outputs("reset", '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    run_op(DW'(1000), 8'd7, N, N, 1'b0);
    check_outputs("d1000", DW'(142), 8'd6, 1'b0, 1'b0);

    run_op(ones, 8'd255, N, N, 1'b0);
    check("allones_q", quotient, {50{8'h01}});
    check("allones_r", DW'(remainder), DW'(0));

    run_op(DW'(1234567), 8'd0, 0, 0, 1'b0);
    check_outputs("dbz", ones, 8'd0, 1'b1, 1'b0);

    run_op(ones, 8'd1, N, N, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 13; w++) a = {a[DW-33:0], 32'($urandom)};
      run_op(a, 8'($urandom_range(1, 255)), N, N, 1'b0);
    end

    // abort mid-run keeps the previous result
    run_op(DW'(1000), 8'd7, N, N, 1'b0);
    start = 1'b1; dividend = DW'(999999); divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_outputs("abort", DW'(142), 8'd6, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    check("abort_idle_busy", DW'(busy), DW'(0));
    for (int w = 0; w < 13; w++) a = {a[DW-33:0], 32'($urandom)};
    run_op(a, 8'd13, N, N, 1'b1);

    // reset mid-run, with start asserted during reset
    start = 1'b1; dividend = DW'(55555); divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    check_outputs("midreset", '0, '0, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("start_in_reset_busy", DW'(busy), DW'(0));
    run_op(DW'(77777), 8'd200, N, N, 1'b0);

    s_start = 1'b1; s_dividend = '1; s_divisor = 16'hFFFF;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      s_start = 1'b0;
    end while (!s_done && c < 100);
    check("w64_latency", DW'(c - 1), DW'(16));
    check("w64_q", DW'(s_quotient), DW'(64'h0001000100010001));
    check("w64_r", DW'(s_remainder), DW'(0));
    check("w64_dbz", DW'(s_dbz), DW'(0));
    check("w64_busy", DW'(s_busy), DW'(0));

    repeat (2) @(negedge clk);
    check("sb_drained", DW'(sb.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_divider.md
DIGIT_SERIAL_DIVIDER -- requirements
Module: digit_serial_divider

Interface
REQ-001 The block SHALL have parameter DW, default 400, meaning dividend/quotient width in bits.
REQ-002 The block SHALL have parameter VW, default 8, meaning divisor/remainder width in bits.
REQ-003 The block SHALL have parameter DGT, default 8, meaning dividend bits consumed per compute cycle; DW SHALL be a multiple of DGT, and N = DW/DGT.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, a synchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1, a request to begin a division.
REQ-007 The block SHALL have port abort, input, 1, which cancels a running division.
REQ-008 The block SHALL have port dividend, input, DW, the operand sampled only at start acceptance.
REQ-009 The block SHALL have port divisor, input, VW, the operand sampled only at start acceptance.
REQ-010 The block SHALL have port quotient, output, DW, the last completed quotient.
REQ-011 The block SHALL have port remainder, output, VW, the last completed remainder.
REQ-012 The block SHALL have port busy, output, 1, high while in RUN.
REQ-013 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-014 The block SHALL have port dbz, output, 1, a divide-by-zero flag for the last completed operation.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE.
REQ-016 start SHALL be accepted at an edge in IDLE or DONE: the block latches dividend and divisor, clears the residue and digit index, and enters RUN with busy=1.
REQ-017 start in RUN SHALL be ignored; operand inputs changing during RUN SHALL NOT affect the result.
REQ-018 In RUN, each edge SHALL form cur = {residue, next DGT-bit dividend digit, MSB first}, write cur/divisor into the working quotient digit, and set residue = cur % divisor; cur is VW+DGT bits wide and each quotient digit fits in DGT bits.
REQ-019 After the N-th compute edge, the block SHALL copy the working quotient to quotient and the residue to remainder, set dbz=0, and enter DONE with done=1 and busy=0.
REQ-020 done SHALL therefore rise exactly N edges after the start-accept edge and last exactly one cycle; DONE SHALL return to IDLE on the next edge unless start is accepted.
REQ-021 If the latched divisor is 0 at acceptance, the block SHALL skip RUN, enter DONE on the accept edge, and set quotient to all ones, remainder to 0 and dbz=1.
REQ-022 abort=1 at an edge in RUN SHALL force IDLE with busy=0 and no done pulse, leaving quotient, remainder and dbz unchanged; abort outside RUN SHALL be ignored.
REQ-023 abort SHALL take priority over completion on the N-th edge.
REQ-024 quotient, remainder and dbz SHALL hold their values until the next completion.

Reset
REQ-025 rst=0 at an edge SHALL force IDLE from any state, including mid-RUN, and SHALL clear quotient, remainder, busy, done, dbz, residue and the index to 0.
REQ-026 start SHALL be ignored at any edge where rst=0.

Structure
REQ-027 State encodings SHALL live in a shared package div_pkg.
REQ-028 The single-digit step (cur/divisor, cur%divisor) SHALL be a combinational sub-module div_digit_step, parametrised by VW and DGT.
REQ-029 The index width SHALL be $clog2(N) and SHALL NOT be hard-coded.

Verification
REQ-030 Defaults, dividend=1000, divisor=7 -> quotient=142, remainder=6, dbz=0, done exactly 50 edges after accept, busy high for 50 cycles.
REQ-031 Defaults, dividend=2^400-1, divisor=255 -> quotient = 50 bytes of 0x01, remainder=0.
REQ-032 divisor=0 -> done on the cycle after accept, quotient all ones, remainder=0, dbz=1, busy never high.
REQ-033 abort at compute cycle 20 after a prior result 142/6 -> busy low next cycle, no done, outputs still 142/6; a new start then completes normally. Also: start pulses and operand changes mid-RUN leave the result unaffected.
REQ-034 rst=0 at compute cycle 30 -> all outputs 0 next cycle, state IDLE; a following start completes in 50 cycles.
REQ-035 DW=64, VW=16, DGT=4, dividend=2^64-1, divisor=0xFFFF -> quotient=0x0001000100010001, remainder=0, done 16 edges after accept.
